// File: rtl/psum_gather_acc.sv
// psum_gather_acc: per-row partial-sum accumulator with holding registers,
// a round-robin drain arbiter and a small output FIFO with valid/ready.
// Optional feature: define PSUM_SAT_EN to saturate accumulation instead of
// wrapping modulo 2^ACC_WIDTH. Overflow is flagged in both builds.
module psum_gather_acc #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH    = 24,
    parameter int unsigned NUM_ROWS     = 16,
    parameter int unsigned MAX_CHANNELS = 64,
    parameter int unsigned MAX_OUTPUTS  = 256,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned LOG_NR      = $clog2(NUM_ROWS),
    localparam int unsigned LOG_MC      = $clog2(MAX_CHANNELS),
    localparam int unsigned LOG_MO      = $clog2(MAX_OUTPUTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_start,
    input  logic [LOG_NR:0]                i_row_num,
    input  logic [NUM_ROWS-1:0]            i_row_en,
    input  logic [LOG_MC:0]                i_num_channels,
    input  logic [LOG_MO:0]                i_num_outputs,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] i_psum_data,
    input  logic [NUM_ROWS-1:0]            i_psum_valid,
    output logic [ACC_WIDTH-1:0]           o_out_data,
    output logic [LOG_NR-1:0]              o_out_row,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic                           o_switch_lane,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_overflow,
    output logic                           o_overrun
);

    localparam int unsigned LOG_FD = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;

    // Job configuration, latched on start
    logic [LOG_NR:0]       row_num_q;
    logic [NUM_ROWS-1:0]   active_q, active_cfg;
    logic [LOG_MC:0]       num_ch_q, num_ch_cfg;
    logic [LOG_MO:0]       num_out_q;

    // Per-row accumulation state
    logic [ACC_WIDTH-1:0]  acc_q     [NUM_ROWS];
    logic [ACC_WIDTH-1:0]  acc_d     [NUM_ROWS];
    logic [LOG_MC:0]       ch_cnt_q  [NUM_ROWS];
    logic [LOG_MC:0]       ch_cnt_d  [NUM_ROWS];
    logic [LOG_MO:0]       out_cnt_q [NUM_ROWS];
    logic [LOG_MO:0]       out_cnt_d [NUM_ROWS];
    logic [ACC_WIDTH-1:0]  hold_q    [NUM_ROWS];
    logic [ACC_WIDTH-1:0]  hold_d    [NUM_ROWS];
    logic [NUM_ROWS-1:0]   pend_q, pend_d;

    logic [LOG_NR-1:0]     rr_q, rr_d;
    logic                  switch_q, switch_d;
    logic                  overflow_q, overflow_d;
    logic                  overrun_q, overrun_d;

    // Output FIFO
    logic [ACC_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [LOG_NR-1:0]     fifo_row_q  [FIFO_DEPTH];
    logic [LOG_FD-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LOG_FD-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LOG_FD:0]       count_q, count_d;

    // Combinational helpers
    logic                  start_job;
    logic                  rows_done;
    logic                  done;
    logic                  fifo_full;
    logic                  pop;
    logic                  xfer;
    logic                  grant_vld;
    logic [LOG_NR-1:0]     grant_idx;
    logic [LOG_NR-1:0]     cand;

    logic signed [DATA_WIDTH-1:0] psum_s;
    logic [ACC_WIDTH-1:0]         psum_ext;
    logic [ACC_WIDTH:0]           sum_ext;
    logic [ACC_WIDTH-1:0]         res;
    logic                         ovf;
    logic                         accept;
    logic                         last_ch;

    assign start_job   = (state_q == StIdle) && i_start;
    assign fifo_full   = (count_q == (LOG_FD+1)'(FIFO_DEPTH));
    assign o_out_valid = (count_q != '0);
    assign pop         = o_out_valid && i_out_ready;
    // A full FIFO can still accept a push when the head leaves in the same cycle
    assign xfer        = grant_vld && (!fifo_full || pop);

    assign o_out_data    = o_out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign o_out_row     = o_out_valid ? fifo_row_q[rd_ptr_q] : '0;
    assign o_switch_lane = switch_q;
    assign o_busy        = (state_q != StIdle);
    assign o_done        = done;
    assign o_overflow    = overflow_q;
    assign o_overrun     = overrun_q;

    // Decode the job configuration presented with i_start
    always_comb begin
        active_cfg = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            active_cfg[r] = ((LOG_NR+1)'(r) < i_row_num) && i_row_en[r];
        end
        num_ch_cfg = (i_num_channels == '0) ? (LOG_MC+1)'(1) : i_num_channels;
    end

    // Round-robin pick: lowest pending row at or after the pointer, wrapping
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            cand = LOG_NR'((int'(rr_q) + i) % NUM_ROWS);
            if (pend_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Every active row has produced its full quota of results
    always_comb begin
        rows_done = 1'b1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (active_q[r] && (out_cnt_q[r] != num_out_q)) begin
                rows_done = 1'b0;
            end
        end
    end

    // FSM next state and done pulse
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StRun;
            end
            StRun: begin
                if (rows_done) state_d = StDrain;
            end
            StDrain: begin
                if ((pend_q == '0) && (count_q == '0)) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Per-row accumulate, result hand-off to holding registers, sticky flags
    always_comb begin
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        switch_d   = 1'b0;
        pend_d     = pend_q;
        psum_s     = '0;
        psum_ext   = '0;
        sum_ext    = '0;
        res        = '0;
        ovf        = 1'b0;
        accept     = 1'b0;
        last_ch    = 1'b0;
        if (xfer) pend_d[grant_idx] = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            acc_d[r]     = acc_q[r];
            ch_cnt_d[r]  = ch_cnt_q[r];
            out_cnt_d[r] = out_cnt_q[r];
            hold_d[r]    = hold_q[r];

            psum_s   = i_psum_data[r*DATA_WIDTH +: DATA_WIDTH];
            psum_ext = ACC_WIDTH'(psum_s);
            // One extra bit exposes signed overflow as a sign disagreement
            sum_ext  = {acc_q[r][ACC_WIDTH-1], acc_q[r]} + {psum_ext[ACC_WIDTH-1], psum_ext};
            ovf      = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
`ifdef PSUM_SAT_EN
            if (ovf) begin
                res = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                res = sum_ext[ACC_WIDTH-1:0];
            end
`else
            res = sum_ext[ACC_WIDTH-1:0];
`endif
            accept  = (state_q == StRun) && active_q[r] && i_psum_valid[r] &&
                      (out_cnt_q[r] != num_out_q);
            last_ch = ((ch_cnt_q[r] + 1'b1) == num_ch_q);

            if (accept) begin
                if (ovf) overflow_d = 1'b1;
                if (last_ch) begin
                    acc_d[r]     = '0;
                    ch_cnt_d[r]  = '0;
                    out_cnt_d[r] = out_cnt_q[r] + 1'b1;
                    // Holding register frees up this cycle only if it is being drained
                    if (pend_q[r] && !(xfer && (grant_idx == LOG_NR'(r)))) begin
                        overrun_d = 1'b1;
                    end else begin
                        hold_d[r] = res;
                        pend_d[r] = 1'b1;
                    end
                    if ((LOG_NR+1)'(r) == (row_num_q - 1'b1)) switch_d = 1'b1;
                end else begin
                    acc_d[r]    = res;
                    ch_cnt_d[r] = ch_cnt_q[r] + 1'b1;
                end
            end

            if (start_job) begin
                acc_d[r]     = '0;
                ch_cnt_d[r]  = '0;
                out_cnt_d[r] = '0;
                hold_d[r]    = '0;
            end
        end
        if (start_job) begin
            pend_d     = '0;
            overflow_d = 1'b0;
            overrun_d  = 1'b0;
            switch_d   = 1'b0;
        end
    end

    // Arbiter pointer and FIFO pointer/occupancy next state
    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (xfer) begin
            rr_d = (grant_idx == LOG_NR'(NUM_ROWS - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (start_job) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (xfer) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (xfer && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!xfer && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            row_num_q  <= '0;
            active_q   <= '0;
            num_ch_q   <= '0;
            num_out_q  <= '0;
            pend_q     <= '0;
            rr_q       <= '0;
            switch_q   <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                acc_q[r]     <= '0;
                ch_cnt_q[r]  <= '0;
                out_cnt_q[r] <= '0;
                hold_q[r]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            switch_q   <= switch_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int r = 0; r < NUM_ROWS; r++) begin
                acc_q[r]     <= acc_d[r];
                ch_cnt_q[r]  <= ch_cnt_d[r];
                out_cnt_q[r] <= out_cnt_d[r];
                hold_q[r]    <= hold_d[r];
            end
            if (start_job) begin
                row_num_q <= i_row_num;
                active_q  <= active_cfg;
                num_ch_q  <= num_ch_cfg;
                num_out_q <= i_num_outputs;
            end
        end
    end

    // FIFO storage; contents are only observed while the entry is valid
    always_ff @(posedge clk) begin
        if (xfer) begin
            fifo_data_q[wr_ptr_q] <= hold_q[grant_idx];
            fifo_row_q[wr_ptr_q]  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_psum_gather_acc.sv
// Scoreboard bench for psum_gather_acc: stimulus pushes expected results into
// a queue, a negedge monitor pops and compares on every accepted output.
module tb_psum_gather_acc;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned NR = 16;
    localparam int unsigned MC = 64;
    localparam int unsigned MO = 256;
    localparam int unsigned FD = 4;

`ifdef PSUM_SAT_EN
    localparam logic [AW-1:0] EXP_POS = 16'h7FFF;
    localparam logic [AW-1:0] EXP_NEG = 16'h8000;
`else
    localparam logic [AW-1:0] EXP_POS = 16'h8000;
    localparam logic [AW-1:0] EXP_NEG = 16'h7FFF;
`endif

    typedef struct packed {
        logic [3:0]    row;
        logic [AW-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_start;
    logic [4:0]        i_row_num;
    logic [NR-1:0]     i_row_en;
    logic [6:0]        i_num_channels;
    logic [8:0]        i_num_outputs;
    logic [NR*DW-1:0]  i_psum_data;
    logic [NR-1:0]     i_psum_valid;
    logic [AW-1:0]     o_out_data;
    logic [3:0]        o_out_row;
    logic              o_out_valid;
    logic              i_out_ready;
    logic              o_switch_lane;
    logic              o_busy;
    logic              o_done;
    logic              o_overflow;
    logic              o_overrun;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   sw_cnt   = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    psum_gather_acc #(
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW),
        .NUM_ROWS    (NR),
        .MAX_CHANNELS(MC),
        .MAX_OUTPUTS (MO),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_row_num     (i_row_num),
        .i_row_en      (i_row_en),
        .i_num_channels(i_num_channels),
        .i_num_outputs (i_num_outputs),
        .i_psum_data   (i_psum_data),
        .i_psum_valid  (i_psum_valid),
        .o_out_data    (o_out_data),
        .o_out_row     (o_out_row),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_switch_lane (o_switch_lane),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int row, input logic [AW-1:0] data);
        exp_t e;
        e.row  = 4'(row);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_row(input int row, input logic [DW-1:0] val);
        i_psum_data[row*DW +: DW] = val;
    endtask

    task automatic psum_all(input logic [NR-1:0] mask, input logic [DW-1:0] val);
        for (int r = 0; r < NR; r++) set_row(r, val);
        i_psum_valid = mask;
        tick();
        i_psum_valid = '0;
    endtask

    task automatic start_job(input logic [4:0] rn, input logic [NR-1:0] en,
                             input logic [6:0] nch, input logic [8:0] nout);
        i_row_num      = rn;
        i_row_en       = en;
        i_num_channels = nch;
        i_num_outputs  = nout;
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < budget) begin
            tick();
            n++;
        end
        check("done_pulse_count", done_cnt - c0, 1);
        check("idle_after_done", o_busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    // Monitor: pop expected entries whenever the DUT hands off a result
    always @(negedge clk) begin
        if (reset) begin
            if (o_switch_lane) sw_cnt++;
            if (o_done) begin
                done_cnt++;
                check("done_after_last_pop", exp_q.size(), 0);
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got row %0d data 0x%0h, expected none",
                             o_out_row, o_out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", o_out_data, e.data);
                    check("out_row", o_out_row, e.row);
                end
            end
        end
    end

    // Hard stop in case the design never finishes
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        i_start        = 1'b0;
        i_row_num      = '0;
        i_row_en       = '0;
        i_num_channels = '0;
        i_num_outputs  = '0;
        i_psum_data    = '0;
        i_psum_valid   = '0;
        i_out_ready    = 1'b0;
        tick();
        tick();
        check("rst_out_valid", o_out_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_switch", o_switch_lane, 0);
        reset = 1'b1;
        tick();

        // Four rows, three channels in lockstep: 5 - 2 + 7 = 10
        i_out_ready = 1'b1;
        sw_cnt      = 0;
        start_job(5'd4, 16'h000F, 7'd3, 9'd1);
        for (int r = 0; r < 4; r++) expect_out(r, 16'd10);
        psum_all(16'h000F, 16'd5);
        psum_all(16'h000F, 16'hFFFE);
        psum_all(16'h000F, 16'd7);
        wait_done(50);
        check("t1_switch_pulses", sw_cnt, 1);
        check("t1_overflow", o_overflow, 0);
        check("t1_overrun", o_overrun, 0);

        // Single row, single channel: latency of the hand-off
        sw_cnt = 0;
        start_job(5'd1, 16'h0001, 7'd1, 9'd1);
        set_row(0, 16'h1234);
        expect_out(0, 16'h1234);
        i_psum_valid = 16'h0001;
        tick();
        i_psum_valid = '0;
        check("t2_valid_after_k", o_out_valid, 0);
        check("t2_switch_after_k", o_switch_lane, 1);
        tick();
        check("t2_valid_after_k1", o_out_valid, 1);
        check("t2_data_after_k1", o_out_data, 16'h1234);
        check("t2_row_after_k1", o_out_row, 0);
        check("t2_switch_after_k1", o_switch_lane, 0);
        wait_done(50);

        // Eight rows finish together against a stalled consumer; pointer sits at 1
        i_out_ready = 1'b0;
        start_job(5'd8, 16'h00FF, 7'd1, 9'd1);
        for (int r = 0; r < 8; r++) set_row(r, 16'(100 + r));
        for (int k = 1; k <= 8; k++) expect_out(k % 8, 16'(100 + (k % 8)));
        i_psum_valid = 16'h00FF;
        tick();
        i_psum_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        check("t3_head_valid", o_out_valid, 1);
        check("t3_head_row", o_out_row, 1);
        check("t3_still_busy", o_busy, 1);
        check("t3_no_overrun", o_overrun, 0);
        i_out_ready = 1'b1;
        wait_done(60);
        check("t3_overrun_end", o_overrun, 0);

        // Six results on one row with a stalled consumer: the sixth is dropped
        i_out_ready = 1'b0;
        sw_cnt      = 0;
        start_job(5'd1, 16'h0001, 7'd1, 9'd6);
        for (int v = 1; v <= 6; v++) begin
            if (v <= 5) expect_out(0, 16'(v * 11));
            set_row(0, 16'(v * 11));
            i_psum_valid = 16'h0001;
            tick();
        end
        i_psum_valid = '0;
        tick();
        tick();
        check("t4_overrun", o_overrun, 1);
        check("t4_head_data", o_out_data, 16'd11);
        i_out_ready = 1'b1;
        wait_done(60);
        check("t4_overrun_sticky", o_overrun, 1);
        check("t4_switch_pulses", sw_cnt, 6);

        // Overflow at both signed extremes, two channels per result
        start_job(5'd1, 16'h0001, 7'd2, 9'd2);
        check("t5_overrun_cleared", o_overrun, 0);
        check("t5_overflow_clear", o_overflow, 0);
        expect_out(0, EXP_POS);
        expect_out(0, EXP_NEG);
        psum_all(16'h0001, 16'h7FFF);
        psum_all(16'h0001, 16'h0001);
        psum_all(16'h0001, 16'h8000);
        psum_all(16'h0001, 16'hFFFF);
        wait_done(50);
        check("t5_overflow", o_overflow, 1);

        // Reset mid-job with queued and pending data, then a clean job
        i_out_ready = 1'b0;
        start_job(5'd2, 16'h0003, 7'd1, 9'd2);
        psum_all(16'h0003, 16'd9);
        tick();
        tick();
        check("t6_valid_before_reset", o_out_valid, 1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_valid", o_out_valid, 0);
        check("t6_rst_data", o_out_data, 0);
        check("t6_rst_row", o_out_row, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_switch", o_switch_lane, 0);
        check("t6_rst_overflow", o_overflow, 0);
        check("t6_rst_overrun", o_overrun, 0);
        tick();
        reset       = 1'b1;
        i_out_ready = 1'b1;
        tick();
        start_job(5'd1, 16'h0001, 7'd2, 9'd1);
        expect_out(0, 16'd7);
        psum_all(16'h0001, 16'd3);
        psum_all(16'h0001, 16'd4);
        wait_done(50);
        check("t6_overrun_after", o_overrun, 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_gather_acc.md
# psum_gather_acc

Multi-channel partial-sum gatherer that sits between the PE rows of a cluster and the global buffer write port, replacing the single wired-OR output of the previous cluster generation. Each PE row emits one psum per channel of an output pixel. The block accumulates `NUM_CHANNELS` consecutive psums per row into a wider accumulator and parks each completed result in a per-row holding register. Holding registers are drained round-robin into an output FIFO with valid/ready backpressure. It also generates the lane-switch pulse from the last active row.

## Interface
Parameters:
- `DATA_WIDTH`, 16: PE psum width, signed two's complement.
- `ACC_WIDTH`, 24: accumulator/output width; must be ≥ `DATA_WIDTH`.
- `NUM_ROWS`, 16: number of PE rows; `LOG_NR = $clog2(NUM_ROWS)`.
- `MAX_CHANNELS`, 64: `LOG_MC = $clog2(MAX_CHANNELS)`.
- `MAX_OUTPUTS`, 256: results per row per job; `LOG_MO = $clog2(MAX_OUTPUTS)`.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `i_start` in 1: job start pulse; sampled only in IDLE.
- `i_row_num` in LOG_NR+1: rows in use, 1..NUM_ROWS.
- `i_row_en` in NUM_ROWS: per-row enable.
- `i_num_channels` in LOG_MC+1: psums per result; 0 is treated as 1.
- `i_num_outputs` in LOG_MO+1: results expected per active row.
- `i_psum_data` in NUM_ROWS×DATA_WIDTH: per-row psum.
- `i_psum_valid` in NUM_ROWS: per-row psum strobe.
- `o_out_data` out ACC_WIDTH: FIFO head result.
- `o_out_row` out LOG_NR: row index of the head result.
- `o_out_valid` out 1: FIFO not empty.
- `i_out_ready` in 1: consumer accepts the head.
- `o_switch_lane` out 1: one-cycle pulse.
- `o_busy` out 1: state ≠ IDLE.
- `o_done` out 1: one-cycle pulse at job end.
- `o_overflow` out 1: sticky arithmetic overflow flag.
- `o_overrun` out 1: sticky dropped-result flag.

## Operation
- Configuration is latched on `i_start` in IDLE. A row is *active* when its index is < `i_row_num` and its `i_row_en` bit is set. Latching clears the accumulators, channel and output counters, holding registers, FIFO, `o_overflow` and `o_overrun`.
- FSM states:
  - IDLE → RUN on `i_start`.
  - RUN → DRAIN when every active row's output count equals `i_num_outputs`. This happens immediately if there are no active rows or `i_num_outputs`=0.
  - DRAIN → IDLE when no holding register is pending and the FIFO is empty; `o_done` pulses on that transition.
- Per active row, in RUN only, on `i_psum_valid`:
  - Sign-extend the psum to `ACC_WIDTH`, add it to the accumulator and increment the channel counter.
  - On the last channel, load acc+psum into the holding register, set pending, clear the accumulator and channel counter, and increment the output count.
- `i_psum_valid` is ignored in IDLE and DRAIN, for inactive rows, and for rows whose output count has reached `i_num_outputs`.
- Row completion while its holding register is still pending: the new result is dropped, the old result is kept, the output count still increments, and `o_overrun` is set.
- Drain arbiter: one transfer per cycle, from the lowest pending row at or after the round-robin pointer, into the FIFO. A transfer occurs when the FIFO is not full, or when it is full and popping in the same cycle. The pointer then advances to the granted row + 1, modulo `NUM_ROWS`. A row may refill its holding register in the same cycle it is granted.
- FIFO pop: `o_out_valid && i_out_ready`. Push and pop in the same cycle leave the count unchanged.
- `o_switch_lane` pulses in the cycle after row `i_row_num-1` completes a result, whether or not that result was dropped.

## Timing
- All outputs reset to 0; the FSM resets to IDLE. Reset mid-job discards everything.
- Latency: a last-channel psum sampled at edge k gives a pending holding register after k. The result is pushed at k+1 if granted, and `o_out_valid` is high after k+1 when the FIFO was empty.
- `o_switch_lane` is high for exactly the cycle after edge k.
- `o_busy` is high from the edge that samples `i_start` until the edge after `o_done`.
- `i_start` while busy is ignored.

## Configuration
- `PSUM_SAT_EN` defined: accumulation saturates to ±(2^(ACC_WIDTH-1)) bounds, i.e. −2^(ACC_WIDTH-1) and 2^(ACC_WIDTH-1)−1. Any clamp sets `o_overflow`.
- Not defined: accumulation wraps modulo 2^ACC_WIDTH. Signed overflow (operands with equal signs giving a result of different sign) still sets `o_overflow`.

## Test plan
- Rows 0–3 active, 3 channels, 1 output, psums 5, −2, 7 on every row in lockstep, `i_out_ready`=1 → four results of 10 with rows 0,1,2,3 in order, one `o_switch_lane` pulse, `o_done` after the last pop.
- Single row, 1 channel, psum at edge k, FIFO empty → `o_out_valid` high after k+1 with the correct value and `o_out_row`.
- `i_out_ready`=0, 8 rows completing together with `FIFO_DEPTH`=4 → exactly 4 entries queue, 4 rows stay pending, no overrun. Then release ready → 8 results in round-robin order.
- Row completes twice while `i_out_ready`=0 and its holding register is blocked → `o_overrun`=1 and the first value is preserved.
- `ACC_WIDTH`=16, psums 0x7FFF + 0x0001 → 0x7FFF with `PSUM_SAT_EN` defined, 0x8000 without; `o_overflow`=1 in both.
- Assert `reset` low mid-RUN with pending data → all outputs 0 and IDLE; a following `i_start` job completes cleanly.
